serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial subtractor. Computes DIFF = A - B - Bin (mod 2^WIDTH) and a borrow-out,
//   using one full-subtractor cell over WIDTH clock cycles, LSB first.
//   Start/busy/done handshake. Low-area arithmetic for the datapath next to the ripple adder.
// PARAMETERS
//   WIDTH   4   operand/result width in bits (>=2); bit 0 = LSB
// PORTS
//   clk     in   1      single clock; all state changes on posedge
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled only when busy=0
//   a       in   WIDTH  minuend, captured when start accepted
//   b       in   WIDTH  subtrahend, captured when start accepted
//   bin     in   1      borrow-in, captured when start accepted
//   busy    out  1      high while operation in progress
//   done    out  1      one-cycle pulse: diff/bout valid
//   diff    out  WIDTH  result, held stable until next accepted start
//   bout    out  1      borrow-out: 1 iff a < b + bin (unsigned)
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, busy=0, done=0, diff=0, bout=0, shift regs/counter=0.
//   States: IDLE, SHIFT (2 states; done is a registered pulse, not a state).
//   IDLE: start=1 at edge E0 -> latch a,b into shift regs, borrow reg<=bin, cnt<=0,
//     state<=SHIFT, busy=1 from E0. start=0 -> stay IDLE.
//   SHIFT: each edge processes bit cnt: d = a0^b0^br; br' = (~a0&b0)|(~a0&br)|(b0&br);
//     d shifted into result MSB side, operands shift right, cnt++.
//   After edge E0+WIDTH (last bit): state<=IDLE, busy<=0, done<=1 for exactly one cycle,
//     diff/bout updated at that same edge (diff assembled in a shadow reg, copied once).
//   Latency: start accepted at E0 -> done high in the cycle after E0+WIDTH (WIDTH+1 edges).
//   diff/bout never show partial results; they change only at the done edge.
//   start while busy=1: ignored, no effect on in-flight op, no queuing.
//   start during the done cycle (busy=0): accepted -> back-to-back ops, 1 op/(WIDTH+1) cycles.
//   a/b/bin changes after acceptance: no effect on in-flight result.
//   Reset mid-operation: abort immediately, all outputs to reset values, no done pulse.
//   Counter width: $clog2(WIDTH+1); no wrap, compare cnt==WIDTH-1 to finish.
// STRUCTURE
//   Package serial_arith_pkg: state encoding localparams (ST_IDLE, ST_SHIFT), shared with
//     future serial adder/comparator blocks.
//   Sub-module full_subtractor (a, b, bin -> d, bout): pure combinational cell, one instance.
//   Top: FSM, counter, operand shift regs, result shadow reg, output regs.
// TESTING (WIDTH=4; check diff/bout on done, done exactly 1 cycle, busy timing)
//   a=0,b=0,bin=0 -> diff=0x0, bout=0, done 5 edges after accept.
//   a=5,b=3,bin=0 -> diff=0x2, bout=0; a=3,b=5,bin=0 -> diff=0xE, bout=1.
//   a=0,b=0,bin=1 -> diff=0xF, bout=1; a=F,b=F,bin=1 -> diff=0xF, bout=1; a=F,b=0,bin=0 -> 0xF,0.
//   start pulsed with a=1,b=0 while busy on a 9-3 op -> ignored, result 0x6, bout=0.
//   start held high: back-to-back 8-1 then 2-7 -> done pulses 5 cycles apart, 0x7/0 then 0xB/1.
//   rst_n low 2 cycles into an op -> busy/done/diff/bout=0 at once, no done; next op correct.
//   Exhaustive: all a,b in 0..15, bin in {0,1} vs reference model {bout,diff}=a-b-bin.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic family (subtractor now,
// adder/comparator later): FSM state encoding and small helpers.
package serial_arith_pkg;

  // Two-state serial engine: waiting for a request, or shifting bits through the cell.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width needed to index WIDTH bit positions without wrapping.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow: borrow when b plus incoming borrow exceeds a.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~a & bin) | (b & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH) with borrow-out,
// one full-subtractor cell reused over WIDTH cycles, LSB first.
// Results are assembled in a shadow register and published only on the
// done edge, so diff/bout never show a partial result.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             br_next;

  // The single arithmetic cell always looks at the current LSBs and running borrow.
  full_subtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .d    (d_bit),
    .bout (br_next)
  );

  // FSM, operand shifting, result assembly and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else begin
      // done is a one-cycle pulse; only the finishing edge raises it.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= br_next;
          res_sh <= {d_bit, res_sh[WIDTH-1:1]};
          if (cnt == LAST_BIT) begin
            // Last bit: publish the completed word and final borrow together.
            diff  <= {d_bit, res_sh[WIDTH-1:1]};
            bout  <= br_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4): handshake timing, corner
// cases, busy-start rejection, back-to-back ops, mid-op reset, exhaustive sweep.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       bout;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tick until done is seen or the bound expires; n = edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
  endtask

  // Full operation with timing, stability and result checks.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin,
                        input logic [3:0] ed, input logic eb, input string tag);
    int         n;
    logic [3:0] prev;
    logic       stable;
    logic       busy_ok;
    prev    = diff;
    stable  = 1'b1;
    busy_ok = 1'b1;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~ta; b = ~tb_v; bin = ~tbin;
    chk({tag, " busy@accept"}, busy, 1);
    chk({tag, " done@accept"}, done, 0);
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      if (diff !== prev || bout === 1'bx) stable = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, " latency"}, n, 4);
    chk({tag, " busy_during"}, busy_ok, 1);
    chk({tag, " diff_stable"}, stable, 1);
    chk({tag, " busy@done"}, busy, 0);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " bout"}, bout, eb);
    tick();
    chk({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    int         n;
    int         gap;
    logic       saw_done;
    logic [4:0] ref5;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst diff", diff, 0);
    chk("rst bout", bout, 0);
    rst_n = 1'b1;
    tick();

    // Directed corner vectors.
    run_op(4'h0, 4'h0, 1'b0, 4'h0, 1'b0, "0-0-0");
    run_op(4'h5, 4'h3, 1'b0, 4'h2, 1'b0, "5-3-0");
    run_op(4'h3, 4'h5, 1'b0, 4'hE, 1'b1, "3-5-0");
    run_op(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, "0-0-1");
    run_op(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "F-F-1");
    run_op(4'hF, 4'h0, 1'b0, 4'hF, 1'b0, "F-0-0");

    // Start pulse while busy must be ignored.
    a = 4'h9; b = 4'h3; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'h1; b = 4'h0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    chk("ignore latency", n, 2);
    chk("ignore diff", diff, 4'h6);
    chk("ignore bout", bout, 0);
    tick();
    chk("ignore no_requeue busy", busy, 0);
    chk("ignore no_requeue done", done, 0);

    // Start held high: back-to-back 8-1 then 2-7.
    a = 4'h8; b = 4'h1; bin = 1'b0; start = 1'b1;
    tick();
    a = 4'h2; b = 4'h7;
    wait_done(n);
    chk("b2b first latency", n, 4);
    chk("b2b first diff", diff, 4'h7);
    chk("b2b first bout", bout, 0);
    wait_done(gap);
    tick();
    gap = 1;
    while (done !== 1'b1 && gap < 12) begin
      tick();
      gap++;
    end
    start = 1'b0;
    chk("b2b done gap", gap, 5);
    chk("b2b second diff", diff, 4'hB);
    chk("b2b second bout", bout, 1);
    tick();
    chk("b2b done pulse", done, 0);
    tick();
    tick();
    chk("b2b stop busy", busy, 0);

    // Reset two cycles into an operation.
    a = 4'h9; b = 4'h2; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst diff", diff, 0);
    chk("midrst bout", bout, 0);
    tick();
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    chk("midrst no_done", saw_done, 0);
    run_op(4'h7, 4'h2, 1'b0, 4'h5, 1'b0, "post_rst 7-2");

    // Exhaustive sweep against 5-bit two's-complement reference.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ref5 = 5'(ia) - 5'(ib) - 5'(ic);
          run_op(4'(ia), 4'(ib), 1'(ic), ref5[3:0], ref5[4], "sweep");
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
